// File: rtl/rto_core_param.sv
//==============================================================================
// rto_core_param : timestamped FIFO that releases each payload when the system
//                  counter reaches its timestamp; late-entry policy, sticky errors.
// Revision 1.0
//==============================================================================
`default_nettype none

module rto_core_param #(
    parameter int TS_W      = 64,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 1024,
    parameter int PROG_FULL = DEPTH - 8,
    parameter int LATE_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      auto_start,
    input  logic                      flush,
    input  logic                      write,
    input  logic [TS_W+DATA_W-1:0]    fifo_din,
    input  logic [TS_W-1:0]           counter,
    input  logic                      err_clear,
    output logic [DATA_W-1:0]         rto_out,
    output logic                      rto_valid,
    output logic                      rto_late,
    output logic                      timestamp_error,
    output logic                      overflow_error,
    output logic [TS_W+DATA_W-1:0]    timestamp_error_data,
    output logic [TS_W+DATA_W-1:0]    overflow_error_data,
    output logic [CNT_W-1:0]          timestamp_error_count,
    output logic [CNT_W-1:0]          overflow_error_count,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int W     = TS_W + DATA_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [LVL_W-1:0] C_PROG_FULL = LVL_W'(PROG_FULL);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};
    localparam bit               C_EMIT_LATE = (LATE_MODE != 0);

    logic [W-1:0]       r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]   r_level;

    logic [DATA_W-1:0]  r_rto_out;
    logic               r_rto_valid;
    logic               r_rto_late;
    logic               r_ts_err;
    logic               r_ov_err;
    logic [W-1:0]       r_ts_data;
    logic [W-1:0]       r_ov_data;
    logic [CNT_W-1:0]   r_ts_cnt;
    logic [CNT_W-1:0]   r_ov_cnt;

    logic               w_full;
    logic               w_empty;
    logic [W-1:0]       w_head;
    logic [TS_W-1:0]    w_head_ts;
    logic [DATA_W-1:0]  w_head_pl;
    logic               w_active;
    logic               w_match;
    logic               w_late;
    logic               w_pop;
    logic               w_push;
    logic               w_ovf;
    logic               w_emit;

    // Full is taken from the registered level, so a pop never frees room for a same-cycle write.
    assign w_full    = (r_level >= C_PROG_FULL);
    assign w_empty   = (r_level == '0);

    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_ts = w_head[W-1:DATA_W];
    assign w_head_pl = w_head[DATA_W-1:0];

    assign w_active  = auto_start & ~flush & ~w_empty;
    assign w_match   = w_active & (w_head_ts == counter);
    assign w_late    = w_active & (counter > w_head_ts);
    assign w_pop     = w_match | w_late;
    assign w_push    = write & ~flush & ~w_full;
    assign w_ovf     = write & ~flush & w_full;
    assign w_emit    = w_match | (w_late & C_EMIT_LATE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rto_out   <= '0;
            r_rto_valid <= 1'b0;
            r_rto_late  <= 1'b0;
        end else begin
            r_rto_valid <= w_emit;
            r_rto_late  <= w_late & C_EMIT_LATE;
            if (w_emit) begin
                r_rto_out <= w_head_pl;
            end
        end
    end

    // err_clear is applied first; an error in the same cycle overrides it with a count of one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts_err  <= 1'b0;
            r_ts_data <= '0;
            r_ts_cnt  <= '0;
        end else begin
            if (err_clear) begin
                r_ts_err <= 1'b0;
                r_ts_cnt <= '0;
            end
            if (w_late) begin
                r_ts_err  <= 1'b1;
                r_ts_data <= w_head;
                if (err_clear) begin
                    r_ts_cnt <= CNT_W'(1);
                end else if (r_ts_cnt != C_CNT_MAX) begin
                    r_ts_cnt <= r_ts_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ov_err  <= 1'b0;
            r_ov_data <= '0;
            r_ov_cnt  <= '0;
        end else begin
            if (err_clear) begin
                r_ov_err <= 1'b0;
                r_ov_cnt <= '0;
            end
            if (w_ovf) begin
                r_ov_err  <= 1'b1;
                r_ov_data <= fifo_din;
                if (err_clear) begin
                    r_ov_cnt <= CNT_W'(1);
                end else if (r_ov_cnt != C_CNT_MAX) begin
                    r_ov_cnt <= r_ov_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rto_out               = r_rto_out;
    assign rto_valid             = r_rto_valid;
    assign rto_late              = r_rto_late;
    assign timestamp_error       = r_ts_err;
    assign overflow_error        = r_ov_err;
    assign timestamp_error_data  = r_ts_data;
    assign overflow_error_data   = r_ov_data;
    assign timestamp_error_count = r_ts_cnt;
    assign overflow_error_count  = r_ov_cnt;
    assign full                  = w_full;
    assign empty                 = w_empty;
    assign level                 = r_level;

endmodule

`default_nettype wire

// File: tb/tb_rto_core_param.sv
//==============================================================================
// tb_rto_core_param : two core instances (drop / emit late policy) driven with
//                     directed and random traffic against a queue-based model.
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_rto_core_param;

    localparam int TS_W   = 16;
    localparam int DATA_W = 16;
    localparam int W      = TS_W + DATA_W;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b1;
    logic              auto_start = 1'b0;
    logic              flush      = 1'b0;
    logic              write      = 1'b0;
    logic              err_clear  = 1'b0;
    logic [W-1:0]      fifo_din   = '0;
    logic [TS_W-1:0]   counter    = '0;

    logic [DATA_W-1:0] o_out   [2];
    logic              o_valid [2];
    logic              o_late  [2];
    logic              o_tse   [2];
    logic              o_ove   [2];
    logic [W-1:0]      o_tsd   [2];
    logic [W-1:0]      o_ovd   [2];
    logic [CNT_W-1:0]  o_tsc   [2];
    logic [CNT_W-1:0]  o_ovc   [2];
    logic              o_full  [2];
    logic              o_empty [2];
    logic [4:0]        o_level [2];

    always #5 clk = ~clk;

    rto_core_param #(.TS_W(TS_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PROG_FULL(8),
                     .LATE_MODE(0), .CNT_W(CNT_W)) u0 (
        .clk(clk), .reset_n(reset_n), .auto_start(auto_start), .flush(flush),
        .write(write), .fifo_din(fifo_din), .counter(counter), .err_clear(err_clear),
        .rto_out(o_out[0]), .rto_valid(o_valid[0]), .rto_late(o_late[0]),
        .timestamp_error(o_tse[0]), .overflow_error(o_ove[0]),
        .timestamp_error_data(o_tsd[0]), .overflow_error_data(o_ovd[0]),
        .timestamp_error_count(o_tsc[0]), .overflow_error_count(o_ovc[0]),
        .full(o_full[0]), .empty(o_empty[0]), .level(o_level[0]));

    rto_core_param #(.TS_W(TS_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PROG_FULL(12),
                     .LATE_MODE(1), .CNT_W(CNT_W)) u1 (
        .clk(clk), .reset_n(reset_n), .auto_start(auto_start), .flush(flush),
        .write(write), .fifo_din(fifo_din), .counter(counter), .err_clear(err_clear),
        .rto_out(o_out[1]), .rto_valid(o_valid[1]), .rto_late(o_late[1]),
        .timestamp_error(o_tse[1]), .overflow_error(o_ove[1]),
        .timestamp_error_data(o_tsd[1]), .overflow_error_data(o_ovd[1]),
        .timestamp_error_count(o_tsc[1]), .overflow_error_count(o_ovc[1]),
        .full(o_full[1]), .empty(o_empty[1]), .level(o_level[1]));

    // Reference state: one entry queue and the visible outputs per instance.
    logic [W-1:0]      q0[$];
    logic [W-1:0]      q1[$];
    logic [DATA_W-1:0] m_out   [2];
    bit                m_valid [2];
    bit                m_late  [2];
    bit                m_tse   [2];
    bit                m_ove   [2];
    logic [W-1:0]      m_tsd   [2];
    logic [W-1:0]      m_ovd   [2];
    int                m_tsc   [2];
    int                m_ovc   [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pf(input int k);
        return (k == 0) ? 8 : 12;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [W-1:0] qfront(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_out[k] = '0; m_valid[k] = 0; m_late[k] = 0; m_tse[k] = 0; m_ove[k] = 0;
            m_tsd[k] = '0; m_ovd[k] = '0; m_tsc[k] = 0; m_ovc[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int           sz;
        bit           is_full;
        bit           pop;
        logic [W-1:0] h;
        logic [TS_W-1:0] hts;
        sz      = qsize(k);
        is_full = (sz >= pf(k));
        pop     = 0;
        m_valid[k] = 0;
        m_late[k]  = 0;
        if (err_clear) begin
            m_tse[k] = 0; m_tsc[k] = 0; m_ove[k] = 0; m_ovc[k] = 0;
        end
        if (!flush && auto_start && sz > 0) begin
            h   = qfront(k);
            hts = h[W-1:DATA_W];
            if (hts == counter) begin
                pop = 1; m_valid[k] = 1; m_out[k] = h[DATA_W-1:0];
            end else if (counter > hts) begin
                pop = 1; m_tse[k] = 1; m_tsd[k] = h;
                if (m_tsc[k] < CMAX) m_tsc[k]++;
                if (k == 1) begin
                    m_valid[k] = 1; m_late[k] = 1; m_out[k] = h[DATA_W-1:0];
                end
            end
        end
        if (write && !flush && is_full) begin
            m_ove[k] = 1; m_ovd[k] = fifo_din;
            if (m_ovc[k] < CMAX) m_ovc[k]++;
        end
        if (flush) begin
            if (k == 0) q0.delete(); else q1.delete();
        end else begin
            if (pop) begin
                if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (write && !is_full) begin
                if (k == 0) q0.push_back(fifo_din); else q1.push_back(fifo_din);
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.rto_out", k),   64'(o_out[k]),   64'(m_out[k]));
            check($sformatf("u%0d.rto_valid", k), 64'(o_valid[k]), 64'(m_valid[k]));
            check($sformatf("u%0d.rto_late", k),  64'(o_late[k]),  64'(m_late[k]));
            check($sformatf("u%0d.ts_err", k),    64'(o_tse[k]),   64'(m_tse[k]));
            check($sformatf("u%0d.ov_err", k),    64'(o_ove[k]),   64'(m_ove[k]));
            check($sformatf("u%0d.ts_data", k),   64'(o_tsd[k]),   64'(m_tsd[k]));
            check($sformatf("u%0d.ov_data", k),   64'(o_ovd[k]),   64'(m_ovd[k]));
            check($sformatf("u%0d.ts_cnt", k),    64'(o_tsc[k]),   64'(m_tsc[k]));
            check($sformatf("u%0d.ov_cnt", k),    64'(o_ovc[k]),   64'(m_ovc[k]));
            check($sformatf("u%0d.full", k),      64'(o_full[k]),  64'(qsize(k) >= pf(k)));
            check($sformatf("u%0d.empty", k),     64'(o_empty[k]), 64'(qsize(k) == 0));
            check($sformatf("u%0d.level", k),     64'(o_level[k]), 64'(qsize(k)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        auto_start = 0; flush = 0; write = 0; err_clear = 0; fifo_din = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [TS_W-1:0]   ts_tab [3];
        logic [DATA_W-1:0] pl_tab [3];
        int                seen_cnt [3];
        logic [DATA_W-1:0] seen_pl  [3];
        int                nseen;
        int                r;
        logic [31:0]       rnd;
        logic [TS_W-1:0]   ts;

        ts_tab = '{16'd10, 16'd20, 16'd30};
        pl_tab = '{16'h00AA, 16'h00BB, 16'h00CC};
        #2;
        do_reset();

        // Release at timestamps 10/20/30 seen while the counter reads 11/21/31.
        auto_start = 1;
        counter    = 0;
        nseen      = 0;
        seen_cnt   = '{0, 0, 0};
        seen_pl    = '{16'h0, 16'h0, 16'h0};
        for (int c = 0; c < 40; c++) begin
            write    = (c < 3);
            fifo_din = (c < 3) ? {ts_tab[c], pl_tab[c]} : '0;
            tick();
            if (o_valid[0] && nseen < 3) begin
                seen_cnt[nseen] = int'(counter) + 1;
                seen_pl[nseen]  = o_out[0];
                nseen++;
            end
            counter = counter + 16'd1;
        end
        write = 0;
        check("t1.nvalid", 64'(nseen), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1.cnt%0d", i), 64'(seen_cnt[i]), 64'(int'(ts_tab[i]) + 1));
            check($sformatf("t1.pl%0d", i),  64'(seen_pl[i]),  64'(pl_tab[i]));
        end
        check("t1.empty", 64'(o_empty[0]), 64'd1);

        // Asynchronous reset with four entries queued.
        for (int i = 0; i < 4; i++) begin
            write = 1; fifo_din = {16'd1000, 16'(16'h0100 + i)};
            tick();
        end
        write = 0;
        check("t6.level_before", 64'(o_level[0]), 64'd4);
        reset_n = 1'b0;
        #1;
        check("t6.out",   64'(o_out[0]),   64'd0);
        check("t6.level", 64'(o_level[0]), 64'd0);
        check("t6.empty", 64'(o_empty[0]), 64'd1);
        model_reset();
        compare_all();
        tick();
        reset_n = 1'b1;

        // Late entry: dropped by u0, emitted flagged by u1; then err_clear.
        do_reset();
        counter = 0; write = 1; fifo_din = {16'd5, 16'h1234};
        tick();
        write = 0; auto_start = 1; counter = 16'd8;
        tick();
        check("t2.valid",  64'(o_valid[0]), 64'd0);
        check("t2.tse",    64'(o_tse[0]),   64'd1);
        check("t2.tsc",    64'(o_tsc[0]),   64'd1);
        check("t2.tsd",    64'(o_tsd[0]),   64'h0005_1234);
        check("t3.valid",  64'(o_valid[1]), 64'd1);
        check("t3.late",   64'(o_late[1]),  64'd1);
        check("t3.out",    64'(o_out[1]),   64'h1234);
        check("t3.tse",    64'(o_tse[1]),   64'd1);
        auto_start = 0; err_clear = 1;
        tick();
        err_clear = 0;
        check("t2.clr_tse", 64'(o_tse[0]), 64'd0);
        check("t2.clr_tsc", 64'(o_tsc[0]), 64'd0);
        check("t2.clr_tsd", 64'(o_tsd[0]), 64'h0005_1234);

        // Ten writes, frozen FIFO: u0 stops at PROG_FULL=8.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            write = 1; fifo_din = {16'(16'h4000 + i), 16'(16'h5000 + i)};
            tick();
        end
        write = 0;
        check("t4.level",  64'(o_level[0]), 64'd8);
        check("t4.full",   64'(o_full[0]),  64'd1);
        check("t4.ovc",    64'(o_ovc[0]),   64'd2);
        check("t4.ovd",    64'(o_ovd[0]),   64'h4009_5009);
        check("t4.level1", 64'(o_level[1]), 64'd10);
        check("t4.ovc1",   64'(o_ovc[1]),   64'd0);

        // Flush with a same-cycle write at level 3.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            write = 1; fifo_din = {16'd900, 16'(i)};
            tick();
        end
        flush = 1; write = 1; fifo_din = 32'hDEAD_BEEF;
        tick();
        flush = 0; write = 0;
        check("t5.level", 64'(o_level[0]), 64'd0);
        check("t5.empty", 64'(o_empty[0]), 64'd1);
        check("t5.ove",   64'(o_ove[0]),   64'd0);

        // Random traffic; second half favours writes and stalls to reach full.
        do_reset();
        counter = 16'd100;
        for (int c = 0; c < 2000; c++) begin
            if (c % 700 == 699) begin
                do_reset();
            end
            if (c < 1000) begin
                auto_start = ($urandom_range(0, 7) != 0);
                write      = ($urandom_range(0, 1) == 1);
            end else begin
                auto_start = ($urandom_range(0, 3) == 0);
                write      = ($urandom_range(0, 3) != 0);
            end
            flush     = ($urandom_range(0, 49) == 0);
            err_clear = ($urandom_range(0, 39) == 0);
            r   = int'($urandom_range(0, 9));
            if (r < 2) ts = counter - 16'($urandom_range(1, 5));
            else       ts = counter + 16'($urandom_range(0, 25));
            rnd      = $urandom;
            fifo_din = {ts, rnd[15:0]};
            tick();
            r = int'($urandom_range(0, 9));
            if (r == 0)      counter = counter + 16'd3;
            else if (r != 1) counter = counter + 16'd1;
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
